// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin arbiter that shares one Wishbone slave port among
// NUM_MASTERS core-side masters (0 = IF, 1 = MEM control, 2 = LSU).
// The grant is held for the owner's whole cyc tenure. When the owner releases,
// the next owner is chosen at that edge, so grant_o never shows an idle cycle
// between owners. A watchdog raises an error if the slave stalls for too long.
module wb_arbiter #(
  parameter int NUM_MASTERS = 3,
  parameter int TIMEOUT     = 255
) (
  input  logic                        clk,
  input  logic                        rst_i,
  // master side
  input  logic [NUM_MASTERS-1:0]      m_cyc_i,
  input  logic [NUM_MASTERS-1:0]      m_stb_i,
  input  logic [NUM_MASTERS-1:0]      m_we_i,
  input  logic [4*NUM_MASTERS-1:0]    m_sel_i,
  input  logic [32*NUM_MASTERS-1:0]   m_adr_i,
  input  logic [32*NUM_MASTERS-1:0]   m_dat_i,
  output logic [31:0]                 m_dat_o,
  output logic [NUM_MASTERS-1:0]      m_ack_o,
  output logic [NUM_MASTERS-1:0]      m_err_o,
  // slave side
  output logic                        s_cyc_o,
  output logic                        s_stb_o,
  output logic                        s_we_o,
  output logic [3:0]                  s_sel_o,
  output logic [31:0]                 s_adr_o,
  output logic [31:0]                 s_dat_o,
  input  logic [31:0]                 s_dat_i,
  input  logic                        s_ack_i,
  input  logic                        s_err_i,
  // status
  output logic [NUM_MASTERS-1:0]      grant_o
);

  localparam int IDX_W   = $clog2(NUM_MASTERS);
  localparam int WD_NEED = $clog2(TIMEOUT + 1);
  // The watchdog is never narrower than 8 bits.
  localparam int WD_W    = (WD_NEED < 8) ? 8 : WD_NEED;

  // Arbitration state
  logic [NUM_MASTERS-1:0] grant;
  logic [NUM_MASTERS-1:0] grant_next;
  logic [IDX_W-1:0]       last;
  logic [IDX_W-1:0]       last_next;
  logic [IDX_W:0]         cand_idx;
  logic                   found;

  // Watchdog state
  logic [WD_W-1:0]        wd;
  logic [WD_W-1:0]        wd_next;
  logic                   force_err;

  // Owner-derived status
  logic                   busy;
  logic                   owner_cyc;
  logic                   owner_stb;
  logic                   owner_we;
  logic                   rearb;

  // Per-master terms masked by that master's grant bit
  logic [3:0]             sel_term [NUM_MASTERS];
  logic [31:0]            adr_term [NUM_MASTERS];
  logic [31:0]            dat_term [NUM_MASTERS];

  assign busy      = |grant;
  assign owner_cyc = |(grant & m_cyc_i);
  assign owner_stb = |(grant & m_stb_i);
  assign owner_we  = |(grant & m_we_i);

  // The grant is only re-evaluated when nobody owns the bus or the owner has
  // dropped cyc; otherwise the current tenure is locked.
  assign rearb = ~busy | ~owner_cyc;

  // A stalled strobe reaching TIMEOUT is terminated with an error this cycle.
  assign force_err = busy && (wd == WD_W'(TIMEOUT));

  // Mask every master's bus fields with its grant bit; grant is one-hot or
  // zero, so OR-ing the terms afterwards gives the owner's fields, or zero
  // when idle.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_route
      assign sel_term[gi] = grant[gi] ? m_sel_i[4*gi +: 4]   : 4'h0;
      assign adr_term[gi] = grant[gi] ? m_adr_i[32*gi +: 32] : 32'h0;
      assign dat_term[gi] = grant[gi] ? m_dat_i[32*gi +: 32] : 32'h0;
    end
  endgenerate

  // Collapse the masked per-master terms onto the slave port.
  always_comb begin
    s_sel_o = 4'h0;
    s_adr_o = 32'h0;
    s_dat_o = 32'h0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      s_sel_o = s_sel_o | sel_term[k];
      s_adr_o = s_adr_o | adr_term[k];
      s_dat_o = s_dat_o | dat_term[k];
    end
  end

  // Slave-side control signals; stb is withheld while the watchdog fires so
  // the stalled access is not presented again.
  assign s_cyc_o = owner_cyc;
  assign s_stb_o = owner_stb & ~force_err;
  assign s_we_o  = owner_we;

  // Responses go straight back, but only to the owner.
  assign m_dat_o = s_dat_i;
  assign m_ack_o = grant & {NUM_MASTERS{s_ack_i}};
  assign m_err_o = grant & {NUM_MASTERS{s_err_i | force_err}};
  assign grant_o = grant;

  // Round-robin search starting just after the most recent owner, so the
  // previous owner is considered last.
  always_comb begin
    grant_next = grant;
    last_next  = last;
    found      = 1'b0;
    cand_idx   = '0;
    if (rearb) begin
      grant_next = '0;
      for (int i = 1; i <= NUM_MASTERS; i++) begin
        cand_idx = {1'b0, last} + (IDX_W+1)'(i);
        if (cand_idx >= (IDX_W+1)'(NUM_MASTERS)) begin
          cand_idx = cand_idx - (IDX_W+1)'(NUM_MASTERS);
        end
        if (!found && m_cyc_i[cand_idx[IDX_W-1:0]]) begin
          found                            = 1'b1;
          grant_next                       = '0;
          grant_next[cand_idx[IDX_W-1:0]]  = 1'b1;
          last_next                        = cand_idx[IDX_W-1:0];
        end
      end
    end
  end

  // Watchdog counts stalled strobe cycles and clears on any response, on an
  // idle strobe, or right after it has forced an error (stb is masked then).
  always_comb begin
    wd_next = '0;
    if (s_stb_o && !s_ack_i && !s_err_i) begin
      wd_next = wd + 1'b1;
    end
  end

  // Arbitration and watchdog registers; reset gives master 0 first priority.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      grant <= '0;
      last  <= IDX_W'(NUM_MASTERS - 1);
      wd    <= '0;
    end else begin
      grant <= grant_next;
      last  <= last_next;
      wd    <= wd_next;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter (3 masters, watchdog TIMEOUT = 4).
// Inputs change 2 time units after a rising edge; outputs are checked 1 unit
// after that, well away from the next edge.
module tb_wb_arbiter;

  localparam int N = 3;

  logic            clk;
  logic            rst_i;
  logic [N-1:0]    m_cyc_i;
  logic [N-1:0]    m_stb_i;
  logic [N-1:0]    m_we_i;
  logic [4*N-1:0]  m_sel_i;
  logic [32*N-1:0] m_adr_i;
  logic [32*N-1:0] m_dat_i;
  logic [31:0]     m_dat_o;
  logic [N-1:0]    m_ack_o;
  logic [N-1:0]    m_err_o;
  logic            s_cyc_o;
  logic            s_stb_o;
  logic            s_we_o;
  logic [3:0]      s_sel_o;
  logic [31:0]     s_adr_o;
  logic [31:0]     s_dat_o;
  logic [31:0]     s_dat_i;
  logic            s_ack_i;
  logic            s_err_i;
  logic [N-1:0]    grant_o;

  logic            auto_ack;
  logic            ack_drv;
  logic            err_drv;

  int checks;
  int fails;

  logic [N-1:0] fair_exp [4];

  // Zero-wait slave: when auto_ack is set it acks every strobe in-cycle.
  assign s_ack_i = auto_ack ? s_stb_o : ack_drv;
  assign s_err_i = err_drv;

  wb_arbiter #(
    .NUM_MASTERS (N),
    .TIMEOUT     (4)
  ) dut (
    .clk     (clk),
    .rst_i   (rst_i),
    .m_cyc_i (m_cyc_i),
    .m_stb_i (m_stb_i),
    .m_we_i  (m_we_i),
    .m_sel_i (m_sel_i),
    .m_adr_i (m_adr_i),
    .m_dat_i (m_dat_i),
    .m_dat_o (m_dat_o),
    .m_ack_o (m_ack_o),
    .m_err_o (m_err_o),
    .s_cyc_o (s_cyc_o),
    .s_stb_o (s_stb_o),
    .s_we_o  (s_we_o),
    .s_sel_o (s_sel_o),
    .s_adr_o (s_adr_o),
    .s_dat_o (s_dat_o),
    .s_dat_i (s_dat_i),
    .s_ack_i (s_ack_i),
    .s_err_i (s_err_i),
    .grant_o (grant_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-22s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_m(input int k, input logic cyc, input logic stb, input logic we,
                       input logic [31:0] adr, input logic [31:0] dat);
    m_cyc_i[k]          = cyc;
    m_stb_i[k]          = stb;
    m_we_i[k]           = we;
    m_sel_i[4*k +: 4]   = 4'hF;
    m_adr_i[32*k +: 32] = adr;
    m_dat_i[32*k +: 32] = dat;
  endtask

  task automatic clear_all();
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
    m_sel_i = '0; m_adr_i = '0; m_dat_i = '0;
    auto_ack = 1'b0; ack_drv = 1'b0; err_drv = 1'b0; s_dat_i = 32'h0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    fair_exp[0] = 3'b001; fair_exp[1] = 3'b010;
    fair_exp[2] = 3'b100; fair_exp[3] = 3'b001;
    clear_all();
    rst_i = 1'b1;

    // ---- reset state ----
    tick(); tick();
    chk("rst_grant", 32'(grant_o), 32'h0);
    chk("rst_scyc", 32'(s_cyc_o), 32'h0);
    chk("rst_last", 32'(dut.last), 32'h2);
    chk("rst_wd", 32'(dut.wd), 32'h0);
    rst_i = 1'b0;
    #1;
    chk("idle_grant", 32'(grant_o), 32'h0);

    // ---- single master 1 read, ack two cycles after grant ----
    set_m(1, 1, 1, 0, 32'h100, 32'h0);
    #1;
    chk("t1_pre_grant", 32'(grant_o), 32'h0);
    tick();
    chk("t1_grant", 32'(grant_o), 32'h2);
    chk("t1_scyc", 32'(s_cyc_o), 32'h1);
    chk("t1_adr", s_adr_o, 32'h100);
    chk("t1_no_ack", 32'(m_ack_o), 32'h0);
    tick(); tick();
    ack_drv = 1'b1; s_dat_i = 32'hCAFE_F00D;
    #1;
    chk("t1_ack", 32'(m_ack_o), 32'h2);
    chk("t1_rdata", m_dat_o, 32'hCAFE_F00D);
    tick();
    ack_drv = 1'b0;
    set_m(1, 0, 0, 0, 32'h0, 32'h0);
    #1;
    chk("t1_cyc_drop", 32'(s_cyc_o), 32'h0);
    tick();
    chk("t1_release", 32'(grant_o), 32'h0);

    // ---- fairness: all masters from reset, 1-cycle acks ----
    do_reset();
    auto_ack = 1'b1;
    set_m(0, 1, 1, 0, 32'h1000, 32'h0);
    set_m(1, 1, 1, 0, 32'h2000, 32'h0);
    set_m(2, 1, 1, 0, 32'h3000, 32'h0);
    for (int j = 0; j < 4; j++) begin
      tick();
      if (j == 1) set_m(0, 1, 1, 0, 32'h1004, 32'h0);
      #1;
      chk($sformatf("fair_grant%0d", j), 32'(grant_o), 32'(fair_exp[j]));
      chk($sformatf("fair_ack%0d", j), 32'(m_ack_o), 32'(fair_exp[j]));
      if (j < 3) begin
        tick();
        set_m(j, 0, 0, 0, 32'h0, 32'h0);
        #1;
        // owner has released but the grant is still held: no idle grant cycle
        chk($sformatf("fair_hold%0d", j), 32'(grant_o), 32'(fair_exp[j]));
      end
    end
    tick();
    set_m(0, 0, 0, 0, 32'h0, 32'h0);
    tick();
    chk("fair_idle", 32'(grant_o), 32'h0);

    // ---- master 0 holds cyc over 4 strobes while master 2 waits ----
    do_reset();
    set_m(0, 1, 1, 0, 32'h200, 32'h0);
    set_m(2, 1, 1, 1, 32'h300, 32'hA5A5_0003);
    tick();
    for (int s = 0; s < 4; s++) begin
      m_adr_i[31:0] = 32'h200 + 32'(4 * s);
      #1;
      chk($sformatf("lock_grant%0d", s), 32'(grant_o), 32'h1);
      chk($sformatf("lock_ack%0d", s), 32'(m_ack_o), 32'h1);
      chk($sformatf("lock_adr%0d", s), s_adr_o, 32'h200 + 32'(4 * s));
      tick();
    end
    set_m(0, 0, 0, 0, 32'h0, 32'h0);
    #1;
    chk("lock_hold", 32'(grant_o), 32'h1);
    tick();
    chk("lock_handover", 32'(grant_o), 32'h4);
    chk("m2_we", 32'(s_we_o), 32'h1);
    chk("m2_wdata", s_dat_o, 32'hA5A5_0003);

    // ---- slave error on master 2's write ----
    auto_ack = 1'b0;
    err_drv  = 1'b1;
    #1;
    chk("err_route", 32'(m_err_o), 32'h4);
    chk("err_no_ack", 32'(m_ack_o), 32'h0);
    tick();
    err_drv = 1'b0;
    set_m(2, 0, 0, 0, 32'h0, 32'h0);
    tick();
    chk("err_idle", 32'(grant_o), 32'h0);

    // ---- watchdog, TIMEOUT = 4, slave never answers ----
    // The cycle s_stb_o rises is cycle 1; the forced error lands in cycle 5.
    set_m(0, 1, 1, 0, 32'h400, 32'h0);
    tick();
    #1;
    chk("wd_stb_rise", 32'(s_stb_o), 32'h1);
    for (int c = 2; c <= 4; c++) begin
      tick();
      #1;
      chk($sformatf("wd_quiet%0d", c), 32'(m_err_o), 32'h0);
    end
    tick();
    #1;
    chk("wd_err", 32'(m_err_o), 32'h1);
    chk("wd_stb_mask", 32'(s_stb_o), 32'h0);
    tick();
    #1;
    chk("wd_cleared", 32'(dut.wd), 32'h0);
    chk("wd_err_gone", 32'(m_err_o), 32'h0);
    chk("wd_stb_back", 32'(s_stb_o), 32'h1);
    set_m(0, 0, 0, 0, 32'h0, 32'h0);
    tick();

    // ---- reset while master 1 owns the bus ----
    set_m(1, 1, 1, 0, 32'h500, 32'h0);
    tick();
    chk("mid_grant", 32'(grant_o), 32'h2);
    set_m(0, 1, 1, 0, 32'h600, 32'h0);
    set_m(2, 1, 1, 0, 32'h700, 32'h0);
    #1;
    rst_i = 1'b1;
    #1;
    chk("mid_rst_scyc", 32'(s_cyc_o), 32'h0);
    chk("mid_rst_grant", 32'(grant_o), 32'h0);
    tick();
    rst_i = 1'b0;
    #1;
    chk("post_rst_idle", 32'(grant_o), 32'h0);
    tick();
    chk("post_rst_m0", 32'(grant_o), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Absolute time bound so the run can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: observed no end of test, required finish within 100000 time units");
    $fatal(1, "simulation time bound expired");
  end

endmodule
